// File: rtl/run_ctrl_pkg.sv
// run_ctrl_pkg: state and halt-cause encodings shared by the run-control slice.
package run_ctrl_pkg;

    typedef enum logic [1:0] {
        HALTED   = 2'd0,
        RUNNING  = 2'd1,
        STEPPING = 2'd2,
        DRAIN    = 2'd3
    } runStateT;

    typedef enum logic [1:0] {
        CAUSE_RESET     = 2'd0,
        CAUSE_HOST      = 2'd1,
        CAUSE_BREAK     = 2'd2,
        CAUSE_STEP_DONE = 2'd3
    } haltCauseT;

endpackage

// File: rtl/run_step_counter.sv
// run_step_counter: step budget load/decrement register and free-running retired-instruction counter.
module run_step_counter #(
    parameter int STEP_W = 16,
    parameter int CNT_W  = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              load,
    input  logic [STEP_W-1:0] loadVal,
    input  logic              dec,
    input  logic              countEn,
    output logic [STEP_W-1:0] stepsLeft,
    output logic              lastStep,
    output logic [CNT_W-1:0]  retiredCount
);

    assign lastStep = stepsLeft == STEP_W'(1);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stepsLeft    <= '0;
            retiredCount <= '0;
        end else begin
            stepsLeft    <= load ? loadVal : dec ? stepsLeft - STEP_W'(1) : stepsLeft;
            retiredCount <= countEn ? retiredCount + CNT_W'(1) : retiredCount;
        end
    end

endmodule

// File: rtl/run_control_unit.sv
// run_control_unit: run/halt/step sequencer gating the core through a registered cpu_en,
// stopping on instruction boundaries on host halt, PC breakpoint or exhausted step budget.
module run_control_unit
    import run_ctrl_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int STEP_W = 16,
    parameter int CNT_W  = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              run_req,
    input  logic              halt_req,
    input  logic              step_req,
    input  logic [STEP_W-1:0] step_count,
    input  logic              bp_enable,
    input  logic [XLEN-1:0]   bp_addr,
    input  logic [XLEN-1:0]   pc,
    input  logic              instr_retire,
    output logic              cpu_en,
    output logic              halted,
    output logic [1:0]        run_state,
    output logic [1:0]        halt_cause,
    output logic [STEP_W-1:0] steps_left,
    output logic [CNT_W-1:0]  retired_count
);

    runStateT  state, nextState;
    haltCauseT cause, nextCause;
    logic      fromStep, bpHit, load, dec, lastStep;

    assign bpHit      = instr_retire & bp_enable & (pc == bp_addr);
    assign dec        = instr_retire & ((state == STEPPING) | ((state == DRAIN) & fromStep));
    assign run_state  = state;
    assign halt_cause = cause;

    always_comb begin
        nextState = state;
        nextCause = cause;
        load      = 1'b0;
        case (state)
            HALTED: begin
                if (!halt_req && step_req && step_count != '0) begin
                    nextState = STEPPING;
                    load      = 1'b1;
                end else if (!halt_req && run_req) begin
                    nextState = RUNNING;
                end
            end
            RUNNING: begin
                if (bpHit) begin
                    nextState = HALTED;
                    nextCause = CAUSE_BREAK;
                end else if (halt_req) begin
                    nextState = instr_retire ? HALTED : DRAIN;
                    nextCause = instr_retire ? CAUSE_HOST : cause;
                end
            end
            STEPPING: begin
                if (bpHit) begin
                    nextState = HALTED;
                    nextCause = CAUSE_BREAK;
                end else if (instr_retire && lastStep) begin
                    nextState = HALTED;
                    nextCause = CAUSE_STEP_DONE;
                end else if (halt_req) begin
                    nextState = instr_retire ? HALTED : DRAIN;
                    nextCause = instr_retire ? CAUSE_HOST : cause;
                end
            end
            DRAIN: begin
                if (instr_retire) begin
                    nextState = HALTED;
                    nextCause = bpHit ? CAUSE_BREAK : CAUSE_HOST;
                end
            end
        endcase
    end

    // cpu_en/halted are flopped from nextState so they move on the same edge as the state
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= HALTED;
            cause    <= CAUSE_RESET;
            cpu_en   <= 1'b0;
            halted   <= 1'b1;
            fromStep <= 1'b0;
        end else begin
            state    <= nextState;
            cause    <= nextCause;
            cpu_en   <= nextState != HALTED;
            halted   <= nextState == HALTED;
            fromStep <= (state == DRAIN) ? fromStep : (state == STEPPING);
        end
    end

    run_step_counter #(
        .STEP_W(STEP_W),
        .CNT_W (CNT_W)
    ) uCounter (
        .CLK         (CLK),
        .RST         (RST),
        .load        (load),
        .loadVal     (step_count),
        .dec         (dec),
        .countEn     (instr_retire & cpu_en),
        .stepsLeft   (steps_left),
        .lastStep    (lastStep),
        .retiredCount(retired_count)
    );

endmodule

// File: doc/run_control_unit.md
Name: run_control_unit

Overview:
- Run-control sequencer in the control unit. It gates the core's advance through a registered clock-enable (cpu_en) driven from the single system clock CLK.
- The host or debug side issues run, halt and N-step commands.
- The block stops the core on instruction boundaries using the core's retire pulse, an optional PC breakpoint and a step counter.
- It reports the halt cause and a free-running retired-instruction count.

Parameters:
- XLEN, 32, width of pc and bp_addr.
- STEP_W, 16, width of step_count and steps_left.
- CNT_W, 32, width of retired_count.

Ports:
- CLK  in  1  system clock; all state updates on rising edge.
- RST  in  1  reset, asynchronous and active-high.
- run_req  in  1  single-cycle pulse; start free run.
- halt_req  in  1  single-cycle pulse; stop at the next instruction boundary.
- step_req  in  1  single-cycle pulse; execute step_count instructions.
- step_count  in  STEP_W  number of steps, sampled when step_req is accepted.
- bp_enable  in  1  breakpoint enable.
- bp_addr  in  XLEN  breakpoint address.
- pc  in  XLEN  address of the instruction retiring this cycle; valid when instr_retire=1.
- instr_retire  in  1  single-cycle pulse from the core per completed instruction.
- cpu_en  out  1  registered core enable.
- halted  out  1  1 when in state HALTED.
- run_state  out  2  current state encoding.
- halt_cause  out  2  0 RESET, 1 HOST, 2 BREAK, 3 STEP_DONE.
- steps_left  out  STEP_W  remaining steps.
- retired_count  out  CNT_W  instructions retired while cpu_en=1.

Behaviour:
- Reset (async, RST=1) forces:
  - run_state=HALTED, cpu_en=0, halted=1.
  - halt_cause=RESET, steps_left=0, retired_count=0.
- Reset asserted mid-run or mid-step aborts immediately; there is no drain.
- States: HALTED=0, RUNNING=1, STEPPING=2, DRAIN=3.
- All outputs are registered. cpu_en=1 exactly in RUNNING, STEPPING and DRAIN.
- Command priority within one cycle: halt_req > step_req > run_req.
- Requests not listed for the current state are ignored, with no side effects.
- "bp_hit" means instr_retire & bp_enable & (pc==bp_addr).
- HALTED:
  - step_req with step_count!=0 -> STEPPING; steps_left<=step_count.
  - step_req with step_count==0 -> ignored.
  - else run_req -> RUNNING.
  - halt_req -> no change, halt_cause unchanged.
  - cpu_en rises on the same edge the state leaves HALTED (latency 1 cycle from request).
- RUNNING:
  - bp_hit -> HALTED, cause BREAK. This outranks a same-cycle halt_req.
  - else halt_req with instr_retire -> HALTED, cause HOST.
  - else halt_req -> DRAIN.
- STEPPING:
  - On instr_retire, steps_left decrements.
  - bp_hit -> HALTED, cause BREAK; steps_left still decrements.
  - else instr_retire with steps_left==1 -> HALTED, cause STEP_DONE, steps_left=0.
  - else halt_req with instr_retire -> HALTED, cause HOST.
  - else halt_req -> DRAIN; steps_left is frozen apart from the final retire decrement.
  - Simultaneous halt_req and last-step retire gives STEP_DONE.
- DRAIN:
  - On instr_retire -> HALTED, cause HOST, or BREAK if bp_hit.
  - If DRAIN was entered from STEPPING, steps_left decrements on that retire.
  - Further halt_req, step_req and run_req are ignored.
- Stop guarantee: the retire in cycle t is the last one. On edge t+1, cpu_en=0 and halted=1 together, so exactly N retires occur for an N-step command.
- retired_count increments on every instr_retire while cpu_en=1, wraps modulo 2^CNT_W, and is cleared only by reset.
- instr_retire while HALTED (protocol violation) is ignored and is not counted.
- bp_enable and bp_addr are sampled live on each retire; changing them while halted is legal.

Decomposition:
- Package run_ctrl_pkg holds:
  - state encodings HALTED, RUNNING, STEPPING, DRAIN;
  - cause codes CAUSE_RESET, CAUSE_HOST, CAUSE_BREAK, CAUSE_STEP_DONE.
- One sub-module, run_step_counter, contains:
  - the STEP_W load/decrement register with a last_step flag (steps_left==1);
  - the CNT_W retired counter.
- The FSM and breakpoint compare stay in run_control_unit.

Test Plan:
- Reset, then release RST -> halted=1, cpu_en=0, halt_cause=0, retired_count=0. Assert RST while RUNNING -> same values immediately, without waiting for a clock edge.
- run_req, then 5 retire pulses, then halt_req with no retire, then a retire 3 cycles later -> RUNNING, then DRAIN, then HALTED with halt_cause=1, retired_count=6, cpu_en=0 on the edge after the 6th retire.
- step_req with step_count=3, then retire on alternate cycles -> steps_left 3,2,1,0; HALTED with halt_cause=3 on the edge after the 3rd retire; retired_count=3; a step_req with step_count=0 afterwards changes nothing.
- bp_enable=1, bp_addr=0x0000_0010, run; retires at pc 0x0,0x4,0x8,0xC,0x10 -> HALTED with halt_cause=2 after the 0x10 retire; retired_count=5.
- Same-cycle run_req+step_req (step_count=2) -> STEPPING. Same-cycle halt_req and last-step retire -> halt_cause=3.
- Preload retired_count to 0xFFFF_FFFF via a run of 2^32-1 retires, or a force in simulation, then one retire -> retired_count=0, with no other side effects.
